// File: rtl/xc_malu_pkg.sv
// Shared definitions for the MALU divider: FSM state encoding and the
// elaboration-time parameter legality check.
package xc_malu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // True when BITS_PER_CYCLE is 1, 2 or 4 and evenly divides XLEN (XLEN >= 8).
  function automatic bit bits_per_cycle_ok(input int xlen, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && (xlen >= 8) && ((xlen % bpc) == 0);
  endfunction

endpackage

// File: rtl/xc_malu_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module xc_malu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] dq,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] dq_next,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN:0]   diff;

  assign shifted  = {rem, dq[XLEN-1]};
  assign diff     = shifted[XLEN:0] - {1'b0, divisor};
  assign q_bit    = (shifted >= {2'b00, divisor});
  assign rem_next = q_bit ? diff : shifted[XLEN:0];
  // The vacated LSB is left clear; the caller merges q_bit into it.
  assign dq_next  = {dq[XLEN-2:0], 1'b0};

endmodule

// File: rtl/xc_malu_divider.sv
// Iterative restoring divider for div/divu/rem/remu with internal sign
// correction and a valid/ready result handshake.
module xc_malu_divider
  import xc_malu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_signed,
  input  logic            op_rem,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  localparam int            ITERS     = XLEN / BITS_PER_CYCLE;
  localparam int            CW        = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

  if (!bits_per_cycle_ok(XLEN, BITS_PER_CYCLE)) begin : g_bad_params
    $error("xc_malu_divider: illegal XLEN/BITS_PER_CYCLE combination");
  end

  div_state_e      state;
  logic [CW-1:0]   count;
  logic            op_rem_q, neg_q, neg_r;
  logic [XLEN-1:0] dq_q, divisor_q;
  logic [XLEN:0]   rem_q;
  logic            accept;
  logic [XLEN-1:0] rs1_mag, rs2_mag, q_fixed, r_fixed;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Two's-complement negation of MIN yields 2^(XLEN-1), which is the exact unsigned magnitude.
  assign rs1_mag = (op_signed && rs1[XLEN-1]) ? -rs1 : rs1;
  assign rs2_mag = (op_signed && rs2[XLEN-1]) ? -rs2 : rs2;

  logic [XLEN:0]             rem_chain [BITS_PER_CYCLE+1];
  logic [XLEN-1:0]           dq_chain  [BITS_PER_CYCLE+1];
  logic [XLEN-1:0]           dq_shift  [BITS_PER_CYCLE];
  logic [BITS_PER_CYCLE-1:0] q_bits;

  assign rem_chain[0] = rem_q;
  assign dq_chain[0]  = dq_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    xc_malu_div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem_chain[i]),
      .dq       (dq_chain[i]),
      .divisor  (divisor_q),
      .rem_next (rem_chain[i+1]),
      .dq_next  (dq_shift[i]),
      .q_bit    (q_bits[i])
    );
    assign dq_chain[i+1] = dq_shift[i] | XLEN'(q_bits[i]);
  end

  assign q_fixed = neg_q ? -dq_q : dq_q;
  assign r_fixed = neg_r ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  // NOTE: operand/working registers carry no reset; the FSM never consumes them before an accept loads them.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_rem_q  <= op_rem;
      neg_q     <= op_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
      neg_r     <= op_signed && rs1[XLEN-1];
      dq_q      <= rs1_mag;
      divisor_q <= rs2_mag;
      rem_q     <= '0;
    end else if (state == RUN) begin
      rem_q <= rem_chain[BITS_PER_CYCLE];
      dq_q  <= dq_chain[BITS_PER_CYCLE];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      state       <= IDLE;
      count       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            if (rs2 == '0) begin
              state       <= DONE;
              result      <= op_rem ? rs1 : '1;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          if (count == LAST_ITER) state <= FIX;
          else                    count <= count + 1'b1;
        end
        FIX: begin
          result <= op_rem_q ? r_fixed : q_fixed;
          state  <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule
